// File: rtl/cam_capture.sv
// Camera capture stage: samples an OV7670-style parallel bus in the clk domain,
// pairs bytes into RGB444 pixels and writes them to a 160x120 frame buffer.
module cam_capture #(
   parameter int IMG_W = 160,
   parameter int IMG_H = 120,
   parameter int AW    = 15,
   parameter int DW    = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          CAM_PCLK,
   input  logic          CAM_HREF,
   input  logic          CAM_VSYNC,
   input  logic [7:0]    CAM_px_data,
   output logic [AW-1:0] DP_RAM_addr_in,
   output logic [DW-1:0] DP_RAM_data_in,
   output logic          DP_RAM_regW,
   output logic          frame_done
);

   localparam int COLW = $clog2(IMG_W + 1);
   localparam int ROWW = $clog2(IMG_H + 1);
   localparam logic [COLW-1:0] COL_MAX   = COLW'(IMG_W);
   localparam logic [ROWW-1:0] ROW_MAX   = ROWW'(IMG_H);
   localparam logic [AW-1:0]   LINE_STEP = AW'(IMG_W);
   localparam logic [AW-1:0]   LAST_ADDR = AW'(IMG_W * IMG_H - 1);

   typedef enum logic [2:0] {
      WAIT_VS    = 3'd0,
      WAIT_FRAME = 3'd1,
      IDLE       = 3'd2,
      BYTE2      = 3'd3,
      BYTE1      = 3'd4
   } state_t;

   // bus synchronizers: {pclk, href, vsync, data}
   logic [10:0] sync1_d, sync1_q, sync2_d, sync2_q;
   logic        pclk3_d, pclk3_q;
   logic        href_s, vsync_s, pclk_rise;
   logic [7:0]  data_s;

   state_t          state_d, state_q;
   logic [3:0]      hi_d, hi_q;
   logic [COLW-1:0] col_d, col_q;
   logic [ROWW-1:0] row_d, row_q;
   logic [AW-1:0]   wr_addr_d, wr_addr_q;
   logic [AW-1:0]   base_d, base_q;
   logic            line_end;

   // two-stage delay between pixel assembly and the buffer write port
   logic            p1_vld_d, p1_vld_q, p2_vld_d, p2_vld_q;
   logic [AW-1:0]   p1_addr_d, p1_addr_q, p2_addr_d, p2_addr_q;
   logic [DW-1:0]   p1_data_d, p1_data_q, p2_data_d, p2_data_q;
   logic            regw_d, regw_q, fdone_d, fdone_q;
   logic [AW-1:0]   out_addr_d, out_addr_q;
   logic [DW-1:0]   out_data_d, out_data_q;

   always_comb begin
      sync1_d = {CAM_PCLK, CAM_HREF, CAM_VSYNC, CAM_px_data};
      sync2_d = sync1_q;
      pclk3_d = sync2_q[10];
   end

   assign href_s    = sync2_q[9];
   assign vsync_s   = sync2_q[8];
   assign data_s    = sync2_q[7:0];
   assign pclk_rise = sync2_q[10] & ~pclk3_q;

   always_comb begin
      state_d   = state_q;
      hi_d      = hi_q;
      col_d     = col_q;
      row_d     = row_q;
      wr_addr_d = wr_addr_q;
      base_d    = base_q;
      line_end  = 1'b0;
      p1_vld_d  = 1'b0;
      p1_addr_d = p1_addr_q;
      p1_data_d = p1_data_q;

      if (vsync_s) begin
         state_d = WAIT_FRAME;
      end else begin
         case (state_q)
            WAIT_VS: state_d = WAIT_VS;
            WAIT_FRAME: begin
               state_d   = IDLE;
               col_d     = '0;
               row_d     = '0;
               wr_addr_d = '0;
               base_d    = '0;
            end
            IDLE: begin
               if (pclk_rise && href_s) begin
                  hi_d    = data_s[3:0];
                  state_d = BYTE2;
               end
            end
            BYTE2: begin
               if (pclk_rise) begin
                  if (href_s) begin
                     if (col_q < COL_MAX && row_q < ROW_MAX) begin
                        p1_vld_d  = 1'b1;
                        p1_addr_d = wr_addr_q;
                        p1_data_d = DW'({hi_q, data_s});
                        wr_addr_d = wr_addr_q + AW'(1);
                     end
                     if (col_q < COL_MAX) col_d = col_q + COLW'(1);
                     state_d = BYTE1;
                  end else begin
                     line_end = 1'b1;
                     state_d  = IDLE;
                  end
               end
            end
            BYTE1: begin
               if (pclk_rise) begin
                  if (href_s) begin
                     hi_d    = data_s[3:0];
                     state_d = BYTE2;
                  end else begin
                     line_end = 1'b1;
                     state_d  = IDLE;
                  end
               end
            end
            default: state_d = WAIT_VS;
         endcase
      end

      // next line starts at row*IMG_W, tracked as a running line base
      if (line_end) begin
         col_d = '0;
         if (row_q < ROW_MAX) begin
            row_d     = row_q + ROWW'(1);
            base_d    = base_q + LINE_STEP;
            wr_addr_d = base_q + LINE_STEP;
         end
      end
   end

   always_comb begin
      p2_vld_d   = p1_vld_q;
      p2_addr_d  = p1_addr_q;
      p2_data_d  = p1_data_q;
      regw_d     = p2_vld_q;
      out_addr_d = p2_vld_q ? p2_addr_q : out_addr_q;
      out_data_d = p2_vld_q ? p2_data_q : out_data_q;
      fdone_d    = regw_q && (out_addr_q == LAST_ADDR);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         pclk3_q    <= 1'b0;
         state_q    <= WAIT_VS;
         hi_q       <= '0;
         col_q      <= '0;
         row_q      <= '0;
         wr_addr_q  <= '0;
         base_q     <= '0;
         p1_vld_q   <= 1'b0;
         p1_addr_q  <= '0;
         p1_data_q  <= '0;
         p2_vld_q   <= 1'b0;
         p2_addr_q  <= '0;
         p2_data_q  <= '0;
         regw_q     <= 1'b0;
         out_addr_q <= '0;
         out_data_q <= '0;
         fdone_q    <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         pclk3_q    <= pclk3_d;
         state_q    <= state_d;
         hi_q       <= hi_d;
         col_q      <= col_d;
         row_q      <= row_d;
         wr_addr_q  <= wr_addr_d;
         base_q     <= base_d;
         p1_vld_q   <= p1_vld_d;
         p1_addr_q  <= p1_addr_d;
         p1_data_q  <= p1_data_d;
         p2_vld_q   <= p2_vld_d;
         p2_addr_q  <= p2_addr_d;
         p2_data_q  <= p2_data_d;
         regw_q     <= regw_d;
         out_addr_q <= out_addr_d;
         out_data_q <= out_data_d;
         fdone_q    <= fdone_d;
      end
   end

   assign DP_RAM_addr_in = out_addr_q;
   assign DP_RAM_data_in = out_data_q;
   assign DP_RAM_regW    = regw_q;
   assign frame_done     = fdone_q;

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture on a reduced 16x12 image: drives camera frames and
// compares every buffer write against a frame-level reference model.
module tb_cam_capture;

   localparam int IMG_W = 16;
   localparam int IMG_H = 12;
   localparam int AW    = 8;
   localparam int DW    = 12;
   localparam logic [AW-1:0] LAST_A = AW'(IMG_W * IMG_H - 1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          CAM_PCLK = 1'b0;
   logic          CAM_HREF = 1'b0;
   logic          CAM_VSYNC = 1'b0;
   logic [7:0]    CAM_px_data = 8'h00;
   logic [AW-1:0] DP_RAM_addr_in;
   logic [DW-1:0] DP_RAM_data_in;
   logic          DP_RAM_regW;
   logic          frame_done;

   cam_capture #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .DW(DW)) dut (
      .clk            (clk),
      .rst            (rst),
      .CAM_PCLK       (CAM_PCLK),
      .CAM_HREF       (CAM_HREF),
      .CAM_VSYNC      (CAM_VSYNC),
      .CAM_px_data    (CAM_px_data),
      .DP_RAM_addr_in (DP_RAM_addr_in),
      .DP_RAM_data_in (DP_RAM_data_in),
      .DP_RAM_regW    (DP_RAM_regW),
      .frame_done     (frame_done)
   );

   // clock / reset
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   logic [AW+DW-1:0] exp_q[$];
   logic [AW+DW-1:0] obs_q[$];
   int               obs_cyc_q[$];
   int               fd_count = 0;
   int               exp_fd = 0;
   logic             prev_regw = 1'b0;
   logic [AW-1:0]    prev_addr = '0;
   int               pclk_half = 20;
   int               last_rise_cyc = 0;
   int               mark_rise_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // write monitor
   always @(negedge clk) begin
      if (DP_RAM_regW) begin
         obs_q.push_back({DP_RAM_addr_in, DP_RAM_data_in});
         obs_cyc_q.push_back(cyc);
      end
      if (frame_done) begin
         fd_count <= fd_count + 1;
         chk("frame_done_follows_last_write",
             32'((prev_regw && prev_addr == LAST_A) ? 1 : 0), 32'd1);
      end
      prev_regw <= DP_RAM_regW;
      prev_addr <= DP_RAM_addr_in;
   end

   // driver tasks
   task automatic send_byte(input logic [7:0] b, input logic h);
      CAM_PCLK    = 1'b0;
      CAM_HREF    = h;
      CAM_px_data = b;
      #(pclk_half);
      CAM_PCLK      = 1'b1;
      last_rise_cyc = cyc;
      #(pclk_half);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send_byte(8'($urandom), 1'b0);
   endtask

   task automatic clear_obs();
      exp_q.delete();
      obs_q.delete();
      obs_cyc_q.delete();
      fd_count = 0;
      exp_fd   = 0;
   endtask

   // mode 0: alternating 0x0F/0xF0, mode 1: random bytes; abort_line<0 means no abort
   task automatic frame(input int n_lines, input int len0, input int len, input int mode,
                        input int abort_line, input int abort_byte);
      logic [7:0]    lb[$];
      logic [7:0]    hb, lo;
      logic [AW-1:0] a8;
      int            n, kept, a;
      clear_obs();
      CAM_VSYNC = 1'b1;
      idle(3);
      CAM_VSYNC = 1'b0;
      idle(3);
      for (int ln = 0; ln < n_lines; ln++) begin
         n = (ln == 0) ? len0 : len;
         lb.delete();
         for (int i = 0; i < n; i++)
            lb.push_back(mode == 0 ? ((i % 2 == 0) ? 8'h0F : 8'hF0) : 8'($urandom));
         kept = (ln == abort_line) ? abort_byte : n;
         // reference: complete pixel c of line ln lands at ln*IMG_W+c when inside the image
         for (int c = 0; c < kept / 2; c++) begin
            if (ln < IMG_H && c < IMG_W) begin
               a  = ln * IMG_W + c;
               a8 = AW'(a);
               hb = lb[2*c];
               lo = lb[2*c+1];
               exp_q.push_back({a8, hb[3:0], lo});
               if (a == IMG_W * IMG_H - 1) exp_fd = 1;
            end
         end
         for (int i = 0; i < n; i++) begin
            if (ln == abort_line && i == abort_byte) CAM_VSYNC = 1'b1;
            send_byte(lb[i], 1'b1);
            if (ln == 0 && i == 1) mark_rise_cyc = last_rise_cyc;
         end
         idle(3);
         if (ln == abort_line) break;
      end
      idle(4);
   endtask

   // scoreboard
   task automatic check_frame(input string tag);
      int n;
      chk($sformatf("%s_write_count", tag), 32'(obs_q.size()), 32'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_write%0d_addr_data", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
      chk($sformatf("%s_frame_done_count", tag), 32'(fd_count), 32'(exp_fd));
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_addr"}, 32'(DP_RAM_addr_in), 32'd0);
      chk({tag, "_data"}, 32'(DP_RAM_data_in), 32'd0);
      chk({tag, "_regW"}, 32'(DP_RAM_regW), 32'd0);
      chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
   endtask

   initial begin
      // reset held while the bus toggles
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         CAM_VSYNC = 1'($urandom);
         send_byte(8'($urandom), 1'($urandom));
      end
      check_outputs_zero("reset");

      // release mid-line: nothing may be written before a VSYNC fall
      CAM_VSYNC = 1'b0;
      clear_obs();
      send_byte(8'h0F, 1'b1);
      rst = 1'b1;
      for (int i = 0; i < 20; i++) send_byte(8'($urandom), 1'b1);
      idle(6);
      chk("release_midline_no_write", 32'(obs_q.size()), 32'd0);

      // single pixel with latency
      frame(1, 2, 2, 0, -1, 0);
      check_frame("single");
      chk("single_data", 32'(obs_q.size() > 0 ? obs_q[0] : '0), 32'({8'h00, 12'hFF0}));
      chk("single_latency",
          32'(obs_cyc_q.size() > 0 ? obs_cyc_q[0] - mark_rise_cyc : -1), 32'd5);

      // full frame, alternating pattern
      frame(IMG_H, 2 * IMG_W, 2 * IMG_W, 0, -1, 0);
      check_frame("full");

      // asynchronous reset mid-operation, then no capture without a new VSYNC
      rst = 1'b0;
      #1;
      check_outputs_zero("async_reset");
      #9;
      rst = 1'b1;
      clear_obs();
      for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b1);
      idle(6);
      chk("post_reset_no_write", 32'(obs_q.size()), 32'd0);

      // oversize frame
      frame(IMG_H + 2, 2 * IMG_W + 4, 2 * IMG_W + 4, 1, -1, 0);
      check_frame("oversize");

      // odd short line followed by a full line
      frame(2, 7, 2 * IMG_W, 1, -1, 0);
      check_frame("odd_short");

      // VSYNC abort during line 5, then a clean frame restarting at 0
      frame(IMG_H, 2 * IMG_W, 2 * IMG_W, 1, 5, 9);
      check_frame("abort");
      frame(3, 2 * IMG_W, 2 * IMG_W, 1, -1, 0);
      check_frame("after_abort");

      // randomized frames at clk/4 or clk/6
      for (int f = 0; f < 4; f++) begin
         pclk_half = ($urandom_range(0, 1) == 1) ? 30 : 20;
         frame($urandom_range(1, IMG_H + 2), $urandom_range(1, 2 * IMG_W + 5),
               $urandom_range(1, 2 * IMG_W + 5), 1, -1, 0);
         check_frame($sformatf("rand%0d", f));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
